// File: rtl/vga_timing_gen.sv
// Purpose: VGA-style raster timing generator (sync, blanking, position, frame count).
// Latency: every output is registered; the position presented is the one held by
//          the next-position counters at the enabled edge. Backpressure: enable=0 freezes everything.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 12,
  parameter int FRM_W    = 8
) (
  input  logic             pixelClock,
  input  logic             resetN,
  input  logic             enable,
  output logic             hSync,
  output logic             vSync,
  output logic             draw,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             lineStart,
  output logic             frameStart,
  output logic [FRM_W-1:0] frameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject degenerate timings and totals that do not fit the position counters.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CNT_W == 0 || FRM_W == 0 ||
      (H_TOTAL >> CNT_W) != 0 || (V_TOTAL >> CNT_W) != 0) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             H_ON     = (H_POL != 0);
  localparam logic             V_ON     = (V_POL != 0);

  logic [CNT_W-1:0] h_next_q, h_next_d;
  logic [CNT_W-1:0] v_next_q, v_next_d;
  logic [CNT_W-1:0] x_q, y_q;
  logic             hsync_q, vsync_q, draw_q, line_start_q, frame_start_q;
  logic [FRM_W-1:0] frame_cnt_q;
  // Set once the first frame of this reset epoch has started; that first
  // frameStart does not count as a completed frame.
  logic             seen_frame_q;

  logic hsync_d, vsync_d, draw_d, line_start_d, frame_start_d;

  // Next-position arithmetic: horizontal wrap carries into the line counter.
  always_comb begin
    h_next_d = h_next_q + ONE;
    v_next_d = v_next_q;
    if (h_next_q == H_LAST) begin
      h_next_d = '0;
      v_next_d = (v_next_q == V_LAST) ? '0 : v_next_q + ONE;
    end
  end

  // Decode every output from the position about to be presented so they stay aligned.
  always_comb begin
    draw_d        = (h_next_q < H_VIS) && (v_next_q < V_VIS);
    hsync_d       = ((h_next_q >= HS_BEGIN) && (h_next_q < HS_STOP)) ? H_ON : ~H_ON;
    vsync_d       = ((v_next_q >= VS_BEGIN) && (v_next_q < VS_STOP)) ? V_ON : ~V_ON;
    line_start_d  = (h_next_q == '0);
    frame_start_d = (h_next_q == '0) && (v_next_q == '0);
  end

  // Next-position counters advance only on enabled edges.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      h_next_q <= '0;
      v_next_q <= '0;
    end else if (enable) begin
      h_next_q <= h_next_d;
      v_next_q <= v_next_d;
    end
  end

  // Registered outputs; pulses are dropped on disabled edges, levels hold.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      x_q           <= '0;
      y_q           <= '0;
      draw_q        <= 1'b0;
      hsync_q       <= ~H_ON;
      vsync_q       <= ~V_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      seen_frame_q  <= 1'b0;
    end else if (enable) begin
      x_q           <= h_next_q;
      y_q           <= v_next_q;
      draw_q        <= draw_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (frame_start_d) begin
        seen_frame_q <= 1'b1;
        if (seen_frame_q) begin
          frame_cnt_q <= frame_cnt_q + FRM_W'(1);
        end
      end
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign draw       = draw_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;
  assign frameCount = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixel clocks
- H_SYNC, 96, horizontal sync pulse width in pixel clocks
- H_BP, 48, horizontal back porch in pixel clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- H_POL, 0, hSync active level (0 = active-low, 1 = active-high)
- V_POL, 0, vSync active level (0 = active-low, 1 = active-high)
- CNT_W, 12, width of the position counters and of x/y
- FRM_W, 8, width of the frame counter

REQ-002 Ports, one per line (name, direction, width, meaning):
- pixelClock, in, 1, pixel clock; all state changes on its rising edge
- resetN, in, 1, asynchronous active-low reset
- enable, in, 1, pixel advance qualifier
- hSync, out, 1, horizontal sync at level H_POL when active
- vSync, out, 1, vertical sync at level V_POL when active
- draw, out, 1, high while the presented position is visible
- x, out, CNT_W, presented column
- y, out, CNT_W, presented line
- lineStart, out, 1, one-cycle pulse at x==0
- frameStart, out, 1, one-cycle pulse at x==0 and y==0
- frameCount, out, FRM_W, completed-frame counter

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; elaboration error if either is ≥ 2^CNT_W or if any parameter is 0.
REQ-004 Internal next-position counters (hNext, vNext) advance only on edges with enable=1; hNext wraps H_TOTAL-1→0; vNext increments only on an hNext wrap and wraps V_TOTAL-1→0.
REQ-005 All outputs are registered and mutually aligned: on each enabled edge, x/y load the current (hNext, vNext) and every other output is decoded from that same pair.
REQ-006 draw = (x<H_ACTIVE) && (y<V_ACTIVE).
REQ-007 hSync is active iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC; otherwise it is at ~H_POL.
REQ-008 vSync is active iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, for the entire line; otherwise it is at ~V_POL.
REQ-009 lineStart=1 for exactly the one enabled cycle presenting x==0; frameStart=1 for exactly the one presenting (0,0).
REQ-010 frameCount increments by 1, modulo 2^FRM_W, on the same edge that raises frameStart, except the first frameStart after reset, which leaves it at 0.
REQ-011 When enable=0: x, y, hSync, vSync, draw, and frameCount hold; lineStart and frameStart are forced to 0 on that edge; the counters hold.
REQ-012 A vNext wrap coinciding with an hNext wrap produces (0,0) on the next presented position.

Reset
REQ-013 While resetN=0 (asynchronous assert, synchronous to pixelClock on deassert): hNext=vNext=0, x=y=0, draw=0, lineStart=frameStart=0, frameCount=0, hSync=~H_POL, vSync=~V_POL.
REQ-014 The first enabled edge after reset presents (0,0) with draw=1, lineStart=1, frameStart=1, frameCount=0.
REQ-015 Reset asserted mid-frame abandons the frame; there is no partial-frame completion and no frameCount increment.

Verification
REQ-016 Defaults, enable held at 1, reset released → frameStart every 420000 cycles; lineStart every 800 cycles; frameCount reads 0,1,2 at the first three frameStarts.
REQ-017 Defaults → hSync=0 exactly for x 656..751 (96 cycles/line); vSync=0 exactly for y 490..491; draw=1 for 640 cycles on each of lines 0..479 only.
REQ-018 enable toggled 1,0 repeatedly → one full frame takes 840000 cycles; lineStart/frameStart never high for two consecutive cycles; all outputs are stable during enable=0 cycles.
REQ-019 H_POL=1, V_POL=1, small timings (H 4/1/2/1, V 3/1/1/1) → H_TOTAL=8, V_TOTAL=6; hSync=1 only at x=5..6; vSync=1 only at y=4; wrap from (7,5) to (0,0) with frameStart.
REQ-020 resetN pulsed low at x=300,y=200 → outputs immediately take REQ-013 values; the next enabled edge presents (0,0) with frameStart=1 and frameCount=0.
REQ-021 FRM_W=2, 5 frames → frameCount sequence 0,1,2,3,0.
